// File: rtl/uartrx_if.sv
// Line/byte bundle of the UART receive stage: serial line in, framed byte
// and status pulses out. The slave modport is the receiver side.
interface uartrx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       donerx;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input rx_data, donerx, frame_err, busy);
  modport slave  (input rx, output rx_data, donerx, frame_err, busy);
endinterface

// File: rtl/uartrx.sv
// 8N1 UART receiver: synchronizes the line, samples each bit at its centre,
// rejects start glitches and reports stop-bit framing errors.
module uartrx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic     clk,
  input  logic     rst,
  uartrx_if.slave  bus
);
  localparam int N  = clk_freq / baud_rate;
  localparam int H  = N / 2;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] H_LAST = CW'(H - 1);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);
  localparam logic [CW-1:0] N_STOP = CW'(N);

  generate
    if (N < 4) begin : g_bad_rate
      $error("uartrx: clk_freq/baud_rate must be at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_start = 2'd1,
    s_data  = 2'd2,
    s_stop  = 2'd3
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;
  logic [7:0]    rx_data;
  logic          donerx;
  logic          frame_err;
  logic          busy;

  assign bus.rx_data   = rx_data;
  assign bus.donerx    = donerx;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // Frame FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= s_idle;
      cnt       <= '0;
      bitidx    <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        s_idle: begin
          cnt    <= '0;
          bitidx <= 3'd0;
          // Only a true 1->0 transition arms; a line stuck low is ignored.
          if (rxs_d && !rxs) begin
            state <= s_start;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        s_start: begin
          if (cnt == H_LAST) begin
            cnt    <= '0;
            bitidx <= 3'd0;
            if (!rxs) begin
              state <= s_data;
            end else begin
              state <= s_idle;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        s_data: begin
          if (cnt == N_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bitidx == 3'd7) begin
              state <= s_stop;
            end else begin
              bitidx <= bitidx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        s_stop: begin
          // Decide one cycle after the centre sample, which rxs_d still holds.
          if (cnt == N_STOP) begin
            cnt   <= '0;
            state <= s_idle;
            busy  <= 1'b0;
            if (rxs_d) begin
              rx_data <= shreg;
              donerx  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= s_idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uartrx.sv
// Bench for uartrx: planned line waveforms are run against a per-cycle
// reference derived from the frame timing rules, plus directed corner cases.
module tb_uartrx;
  localparam int N = 104;
  localparam int H = 52;

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         stop;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  uartrx_if bus();

  uartrx #(.clk_freq(1000000), .baud_rate(9600)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit pin_q[$];
  bit exp_busy[$];
  bit exp_done[$];
  bit exp_ferr[$];
  logic [7:0] exp_data[$];
  logic [7:0] last_data = 8'h00;

  int win_done, win_ferr, done_at, busy_rise, busy_fall, busy_cnt;
  logic [7:0] done_data[$];
  logic [7:0] ferr_data;
  int hand_pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_level(input bit v, input int n);
    repeat (n) pin_q.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input int p, input bit stop);
    add_level(1'b0, p);
    for (int i = 0; i < 8; i++) add_level(d[i], p);
    add_level(stop, p);
  endtask

  function automatic bit pin_at(input int k);
    if (k < pin_q.size()) return pin_q[k];
    return 1'b1;
  endfunction

  // Reference: pin fall at cycle c gives T0=c+2; bit k is the line value at
  // c-1+H+k*N; result at T0+H+9N+1; a glitch ends at T0+H.
  function automatic void build_expect();
    int len = pin_q.size();
    int nxt = 1;
    int t0, e;
    logic [7:0] b;
    exp_busy.delete(); exp_done.delete(); exp_ferr.delete(); exp_data.delete();
    for (int m = 0; m < len; m++) begin
      exp_busy.push_back(1'b0);
      exp_done.push_back(1'b0);
      exp_ferr.push_back(1'b0);
      exp_data.push_back(last_data);
    end
    for (int c = 1; c < len; c++) begin
      if (c >= nxt && pin_q[c-1] && !pin_q[c]) begin
        t0 = c + 2;
        if (pin_at(c - 1 + H)) begin
          e   = t0 + H;
          nxt = c + H;
        end else begin
          for (int i = 0; i < 8; i++) b[i] = pin_at(c - 1 + H + (i + 1) * N);
          e   = t0 + H + 9 * N + 1;
          nxt = e - 2;
          if (e < len) begin
            if (pin_at(c - 1 + H + 9 * N)) begin
              exp_done[e] = 1'b1;
              last_data   = b;
              for (int m = e; m < len; m++) exp_data[m] = b;
            end else begin
              exp_ferr[e] = 1'b1;
            end
          end
        end
        for (int m = t0 + 1; m < e && m < len; m++) exp_busy[m] = 1'b1;
      end
    end
  endfunction

  task automatic run_window(input string tag);
    int len, mb, md, mf, mx;
    bit prev_busy;
    build_expect();
    len = pin_q.size();
    mb = 0; md = 0; mf = 0; mx = 0;
    win_done = 0; win_ferr = 0; done_at = -1; busy_rise = -1; busy_fall = -1; busy_cnt = 0;
    done_data.delete();
    ferr_data = 8'h00;
    prev_busy = 1'b0;
    for (int m = 0; m < len; m++) begin
      @(posedge clk);
      #1 bus.rx = pin_q[m];
      @(negedge clk);
      if (bus.busy !== exp_busy[m]) mb++;
      if (bus.donerx !== exp_done[m]) md++;
      if (bus.frame_err !== exp_ferr[m]) mf++;
      if (bus.rx_data !== exp_data[m]) mx++;
      if (bus.donerx === 1'b1) begin
        win_done++;
        done_data.push_back(bus.rx_data);
        if (done_at < 0) done_at = m;
      end
      if (bus.frame_err === 1'b1) begin
        win_ferr++;
        ferr_data = bus.rx_data;
      end
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        if (busy_rise < 0) busy_rise = m;
      end else if (prev_busy && busy_fall < 0) begin
        busy_fall = m;
      end
      prev_busy = (bus.busy === 1'b1);
    end
    check({tag, " busy trace mismatches"}, mb, 0);
    check({tag, " donerx trace mismatches"}, md, 0);
    check({tag, " frame_err trace mismatches"}, mf, 0);
    check({tag, " rx_data trace mismatches"}, mx, 0);
    pin_q.delete();
  endtask

  function automatic int done_byte(input int idx);
    if (idx < done_data.size()) return int'(done_data[idx]);
    return -1;
  endfunction

  task automatic drive_cycles(input bit v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 bus.rx = v;
      @(negedge clk);
      if (bus.donerx === 1'b1 || bus.frame_err === 1'b1) hand_pulses++;
    end
  endtask

  initial begin
    vec_t tbl[7];
    logic [7:0] rd;
    tbl[0] = '{8'h5A, 101, 1'b1, 8'h5A, 1, 0};
    tbl[1] = '{8'hC7, 106, 1'b1, 8'hC7, 1, 0};
    tbl[2] = '{8'h00, 104, 1'b1, 8'h00, 1, 0};
    tbl[3] = '{8'hFF, 104, 1'b1, 8'hFF, 1, 0};
    tbl[4] = '{8'h96, 104, 1'b0, 8'hFF, 0, 1};
    tbl[5] = '{8'h6B, 100, 1'b1, 8'h6B, 1, 0};
    tbl[6] = '{8'h3D, 108, 1'b1, 8'h3D, 1, 0};

    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset rx_data", bus.rx_data, 0);
    check("reset donerx", bus.donerx, 0);
    check("reset frame_err", bus.frame_err, 0);
    check("reset busy", bus.busy, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    add_level(1'b1, 20); add_frame(8'h55, N, 1'b1); add_level(1'b1, 30);
    run_window("single55");
    check("single55 done count", win_done, 1);
    check("single55 done cycle", done_at, 20 + 2 + 989);
    check("single55 busy rise", busy_rise, 20 + 3);
    check("single55 busy cycles", busy_cnt, 988);
    check("single55 ferr count", win_ferr, 0);
    check("single55 byte", done_byte(0), 8'h55);

    add_level(1'b1, 20); add_frame(8'hA3, N, 1'b1); add_frame(8'h00, N, 1'b1); add_level(1'b1, 30);
    run_window("b2b");
    check("b2b done count", win_done, 2);
    check("b2b first byte", done_byte(0), 8'hA3);
    check("b2b second byte", done_byte(1), 8'h00);
    check("b2b ferr count", win_ferr, 0);

    add_level(1'b1, 20); add_level(1'b0, 20); add_level(1'b1, 100);
    run_window("glitch");
    check("glitch done count", win_done, 0);
    check("glitch ferr count", win_ferr, 0);
    check("glitch busy fall", busy_fall, 20 + 2 + 52);

    for (int i = 0; i < 7; i++) begin
      add_level(1'b1, 20); add_frame(tbl[i].data, tbl[i].period, tbl[i].stop); add_level(1'b1, 30);
      run_window($sformatf("vec%0d", i));
      check($sformatf("vec%0d done count", i), win_done, tbl[i].exp_done);
      check($sformatf("vec%0d ferr count", i), win_ferr, tbl[i].exp_ferr);
      check($sformatf("vec%0d rx_data", i), bus.rx_data, tbl[i].exp_data);
    end

    add_level(1'b1, 20); add_frame(8'h11, N, 1'b1); add_frame(8'hFF, N, 1'b0);
    add_level(1'b0, 500); add_level(1'b1, 200); add_frame(8'h3C, N, 1'b1); add_level(1'b1, 30);
    run_window("framing");
    check("framing ferr count", win_ferr, 1);
    check("framing data at ferr", ferr_data, 8'h11);
    check("framing done count", win_done, 2);
    check("framing first byte", done_byte(0), 8'h11);
    check("framing last byte", done_byte(1), 8'h3C);

    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
        add_level(1'b1, $urandom_range(1, 25));
        if ($urandom_range(0, 6) == 0)
          add_level(1'b0, $urandom_range(3, 45));
        else
          add_frame(8'($urandom), $urandom_range(100, 108), $urandom_range(0, 5) != 0);
      end
      add_level(1'b1, 30);
      run_window($sformatf("rand%0d", w));
    end

    rd = 8'hE7;
    hand_pulses = 0;
    drive_cycles(1'b1, 20);
    drive_cycles(1'b0, N);
    for (int i = 0; i < 4; i++) drive_cycles(rd[i], N);
    drive_cycles(rd[4], 50);
    check("rst pre busy", bus.busy, 1);
    check("rst pre rx_data", bus.rx_data, last_data);
    #2 rst = 1'b1;
    #1;
    check("rst async rx_data", bus.rx_data, 0);
    check("rst async donerx", bus.donerx, 0);
    check("rst async frame_err", bus.frame_err, 0);
    check("rst async busy", bus.busy, 0);
    drive_cycles(rd[4], N - 50);
    for (int i = 5; i < 8; i++) drive_cycles(rd[i], N);
    drive_cycles(1'b1, N + 20);
    check("rst held pulses", hand_pulses, 0);
    rst = 1'b0;
    last_data = 8'h00;
    add_level(1'b1, 20); add_frame(8'h81, N, 1'b1); add_level(1'b1, 30);
    run_window("after_rst");
    check("after_rst done count", win_done, 1);
    check("after_rst byte", done_byte(0), 8'h81);
    check("after_rst ferr count", win_ferr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
